// File: rtl/sdm_pkg.sv
// Shared types and defaults for the sigma-delta PDM modulator.
// Frame length helper keeps frame math in one place.
package sdm_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN
  } sdm_state_t;

  localparam int DEF_DATA_W  = 8;
  localparam int DEF_CLK_DIV = 1;

  function automatic int unsigned FRAME_LEN(input int unsigned data_w);
    return 32'd1 << data_w;
  endfunction

endpackage

// File: rtl/sigma_delta_mod_if.sv
// Control and stream signals between the register block and the PDM modulator.
// Master drives enable/value; slave returns the bit stream and status.
interface sigma_delta_mod_if;

  logic        enable;
  logic [31:0] value;
  logic        pdm_out;
  logic        busy;
  logic        frame_start;

  modport master (
    output enable,
    output value,
    input  pdm_out,
    input  busy,
    input  frame_start
  );

  modport slave (
    input  enable,
    input  value,
    output pdm_out,
    output busy,
    output frame_start
  );

endinterface

// File: rtl/sdm_tick_gen.sv
// Bit-rate divider: tick asserts combinationally on the last of every CLK_DIV enabled cycles.
// No backpressure; clr holds the count at zero.
module sdm_tick_gen #(
  parameter int CLK_DIV = 1
) (
  input  logic aclk,
  input  logic aresetn,
  input  logic clr,
  input  logic en,
  output logic tick
);

  localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_DIV - 1);

  logic [CNT_W-1:0] div_cnt;

  assign tick = en && (div_cnt == CNT_LAST);

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      div_cnt <= '0;
    end else if (clr) begin
      div_cnt <= '0;
    end else if (en) begin
      div_cnt <= tick ? '0 : div_cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/sigma_delta_mod.sv
// First-order sigma-delta PDM modulator; value is latched per 2^DATA_W-bit frame, one bit per CLK_DIV cycles.
// Registered output, first bit CLK_DIV cycles after RUN entry; no backpressure, stop lands on a frame boundary.
module sigma_delta_mod
  import sdm_pkg::*;
#(
  parameter int DATA_W  = DEF_DATA_W,
  parameter int CLK_DIV = DEF_CLK_DIV
) (
  input logic              aclk,
  input logic              aresetn,
  sigma_delta_mod_if.slave sdm
);

  localparam logic [DATA_W-1:0] FRAME_LAST = DATA_W'(FRAME_LEN(DATA_W) - 1);

  sdm_state_t        state;
  logic [DATA_W-1:0] acc;
  logic [DATA_W-1:0] value_lat;
  logic [DATA_W-1:0] frame_cnt;
  logic [DATA_W-1:0] value_in;
  logic [DATA_W:0]   sum;
  logic              tick;
  logic              tick_clr;
  logic              tick_en;
  logic              advance;
  logic              drain_exit;
  logic              pdm_q;
  logic              busy_q;
  logic              frame_start_q;
  logic              value_unused;

  assign value_in     = sdm.value[DATA_W-1:0];
  assign value_unused = ^sdm.value[31:DATA_W];
  assign tick_clr     = (state == IDLE);
  assign tick_en      = (state != IDLE);

  sdm_tick_gen #(
    .CLK_DIV(CLK_DIV)
  ) u_tick_gen (
    .aclk    (aclk),
    .aresetn (aresetn),
    .clr     (tick_clr),
    .en      (tick_en),
    .tick    (tick)
  );

  // The carry out of the wrapping accumulator is the PDM bit.
  assign sum        = {1'b0, acc} + {1'b0, value_lat};
  assign drain_exit = (state == DRAIN) && !sdm.enable && tick && (frame_cnt == '0);
  assign advance    = tick && !drain_exit;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state         <= IDLE;
      pdm_q         <= 1'b0;
      busy_q        <= 1'b0;
      frame_start_q <= 1'b0;
      acc           <= '0;
      frame_cnt     <= '0;
      value_lat     <= '0;
    end else begin
      frame_start_q <= 1'b0;
      if (advance) begin
        pdm_q     <= sum[DATA_W];
        acc       <= sum[DATA_W-1:0];
        frame_cnt <= frame_cnt + DATA_W'(1);
      end
      unique case (state)
        IDLE: begin
          pdm_q <= 1'b0;
          if (sdm.enable) begin
            state         <= RUN;
            busy_q        <= 1'b1;
            value_lat     <= value_in;
            acc           <= '0;
            frame_cnt     <= '0;
            frame_start_q <= 1'b1;
          end
        end
        RUN: begin
          if (tick && (frame_cnt == FRAME_LAST)) begin
            value_lat     <= value_in;
            frame_start_q <= 1'b1;
          end
          if (!sdm.enable) begin
            state <= DRAIN;
          end
        end
        DRAIN: begin
          // Re-enable resumes seamlessly; otherwise leave on the first tick of the next frame.
          if (drain_exit) begin
            pdm_q  <= 1'b0;
            busy_q <= 1'b0;
            state  <= IDLE;
          end else if (sdm.enable) begin
            state <= RUN;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign sdm.pdm_out     = pdm_q;
  assign sdm.busy        = busy_q;
  assign sdm.frame_start = frame_start_q;

endmodule

// File: tb/tb_sigma_delta_mod.sv
// Bench for sigma_delta_mod: two instances (CLK_DIV=1 and CLK_DIV=4) against a frame-level reference model.
module tb_sigma_delta_mod;

  localparam int FL = 256;

  logic aclk = 1'b0;
  logic aresetn;

  always #5 aclk = ~aclk;

  sigma_delta_mod_if if1 ();
  sigma_delta_mod_if if4 ();

  sigma_delta_mod #(.DATA_W(8), .CLK_DIV(1)) u_dut1 (
    .aclk    (aclk),
    .aresetn (aresetn),
    .sdm     (if1)
  );

  sigma_delta_mod #(.DATA_W(8), .CLK_DIV(4)) u_dut4 (
    .aclk    (aclk),
    .aresetn (aresetn),
    .sdm     (if4)
  );

  int          checks = 0;
  int          errors = 0;
  int          phase  [2];
  int          cur_v  [2];
  logic        en_q   [2];
  logic [31:0] val_q  [2];
  logic [31:0] rv;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic logic pdm(input int s);
    return (s == 0) ? if1.pdm_out : if4.pdm_out;
  endfunction

  function automatic logic bsy(input int s);
    return (s == 0) ? if1.busy : if4.busy;
  endfunction

  function automatic logic fst(input int s);
    return (s == 0) ? if1.frame_start : if4.frame_start;
  endfunction

  task automatic apply(input int s);
    if (s == 0) begin
      if1.enable = en_q[0];
      if1.value  = val_q[0];
    end else begin
      if4.enable = en_q[1];
      if4.value  = val_q[1];
    end
  endtask

  task automatic step();
    @(posedge aclk);
    #1;
  endtask

  // Checks the cycle right after RUN entry and resets the model's accumulator.
  task automatic expect_start(input int s);
    step();
    check("start_frame_start", fst(s), 1);
    check("start_busy", bsy(s), 1);
    check("start_pdm", pdm(s), 0);
    phase[s] = 0;
    cur_v[s] = int'(val_q[s][7:0]);
  endtask

  task automatic start(input int s, input logic [31:0] v);
    val_q[s] = v;
    en_q[s]  = 1'b1;
    apply(s);
    expect_start(s);
  endtask

  // One full frame: each bit is the carry of value added to a running phase mod 256.
  task automatic run_frame(input int s, input int cd, input int chg_k, input logic [31:0] v_next,
                           input int dis_k, input int ren_k, input logic exp_fs);
    int   v;
    int   ones;
    int   bad;
    int   hold_bad;
    int   extra_fs;
    int   tot;
    logic exp_bit;
    logic prev_bit;
    v        = cur_v[s];
    ones     = 0;
    bad      = 0;
    hold_bad = 0;
    extra_fs = 0;
    prev_bit = 1'b0;
    for (int k = 0; k < FL; k++) begin
      if (k == chg_k) begin
        val_q[s] = v_next;
        apply(s);
      end
      if (k == dis_k) begin
        en_q[s] = 1'b0;
        apply(s);
      end
      if (k == ren_k) begin
        en_q[s] = 1'b1;
        apply(s);
      end
      for (int j = 0; j < cd; j++) begin
        step();
        if (!(k == FL - 1 && j == cd - 1) && fst(s) === 1'b1) extra_fs++;
        if (bsy(s) !== 1'b1) bad++;
        if (j < cd - 1) begin
          if (k > 0 && pdm(s) !== prev_bit) hold_bad++;
        end else begin
          tot      = phase[s] + v;
          exp_bit  = (tot >= FL);
          phase[s] = tot % FL;
          if (pdm(s) !== exp_bit) bad++;
          if (pdm(s) === 1'b1) ones++;
          prev_bit = pdm(s);
        end
      end
    end
    check("frame_ones", ones, v);
    check("frame_pattern_errs", bad, 0);
    check("bit_hold_errs", hold_bad, 0);
    check("midframe_frame_start", extra_fs, 0);
    check("boundary_frame_start", fst(s), exp_fs);
    if (exp_fs) cur_v[s] = int'(val_q[s][7:0]);
  endtask

  task automatic drain_exit(input int s, input int cd);
    check("drain_busy_at_boundary", bsy(s), 1);
    repeat (cd) step();
    check("drain_exit_pdm", pdm(s), 0);
    check("drain_exit_busy", bsy(s), 0);
    repeat (3) step();
    check("idle_busy", bsy(s), 0);
    check("idle_frame_start", fst(s), 0);
  endtask

  initial begin
    for (int s = 0; s < 2; s++) begin
      en_q[s]  = 1'b0;
      val_q[s] = '0;
      phase[s] = 0;
      cur_v[s] = 0;
      apply(s);
    end
    aresetn = 1'b0;
    repeat (3) step();
    for (int s = 0; s < 2; s++) begin
      check("rst_pdm", pdm(s), 0);
      check("rst_busy", bsy(s), 0);
      check("rst_frame_start", fst(s), 0);
    end
    aresetn = 1'b1;
    repeat (4) step();
    for (int s = 0; s < 2; s++) begin
      check("idle_pdm", pdm(s), 0);
      check("idle_busy_start", bsy(s), 0);
    end

    // CLK_DIV=1: value 64, switched to 192 at bit 100 of the first frame.
    start(0, 32'd64);
    run_frame(0, 1, 100, 32'd192, -1, -1, 1'b1);
    run_frame(0, 1, $urandom_range(255, 1), 32'd0, -1, -1, 1'b1);
    run_frame(0, 1, $urandom_range(255, 1), 32'd255, -1, -1, 1'b1);
    run_frame(0, 1, $urandom_range(255, 1), 32'hFFFF_FF80, -1, -1, 1'b1);
    run_frame(0, 1, $urandom_range(255, 1), $urandom, -1, -1, 1'b1);
    for (int i = 0; i < 3; i++) begin
      rv = (i == 2) ? 32'd64 : $urandom;
      run_frame(0, 1, $urandom_range(255, 1), rv, -1, -1, 1'b1);
    end

    // Drain with re-enable stays continuous; plain drain returns to IDLE.
    run_frame(0, 1, -1, 32'd64, 50, 200, 1'b1);
    run_frame(0, 1, -1, 32'd64, 50, -1, 1'b0);
    drain_exit(0, 1);

    // CLK_DIV=4: bits held four cycles, 1024-cycle frames.
    start(1, 32'd64);
    run_frame(1, 4, $urandom_range(255, 1), $urandom, -1, -1, 1'b1);
    run_frame(1, 4, -1, 32'd0, 30, -1, 1'b0);
    drain_exit(1, 4);

    // Asynchronous reset mid-frame, then a clean restart.
    start(0, 32'd255);
    repeat (37) step();
    aresetn = 1'b0;
    #1;
    check("async_rst_pdm", pdm(0), 0);
    check("async_rst_busy", bsy(0), 0);
    check("async_rst_frame_start", fst(0), 0);
    val_q[0] = $urandom;
    apply(0);
    #3;
    aresetn = 1'b1;
    expect_start(0);
    run_frame(0, 1, -1, 32'd0, -1, -1, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
